ram_fifo_ctrl: RTL
==================

Name: ram_fifo_ctrl

Overview:
Synchronous FIFO controller that sequences an external ram_2port instance (both RAM clocks tied to i_clk) as circular storage. It owns the write and read pointers, the occupancy count and the full/empty/almost flags. It exposes a valid-strobe push/pop interface to the client and drives the RAM's write and read ports directly. It sits between a streaming producer/consumer pair and the shared dual-port RAM.

Parameters:
WIDTH, 16, data word width; must match the RAM WIDTH.
DEPTH, 256, number of entries; power of two, at least 4; must match the RAM DEPTH.
AF_LEVEL, DEPTH-4, o_af asserts when count >= AF_LEVEL.
AE_LEVEL, 4, o_ae asserts when count <= AE_LEVEL.

Ports:
i_clk  in  1  single clock for controller and RAM.
i_rst  in  1  synchronous, active-high reset.
i_wr_dv  in  1  push strobe; i_wr_data is written when accepted.
i_wr_data  in  WIDTH  push data.
i_rd_en  in  1  pop request.
o_rd_dv  out  1  pop data valid, 1 cycle after an accepted pop.
o_rd_data  out  WIDTH  pop data, valid only while o_rd_dv=1.
o_full  out  1  count == DEPTH.
o_empty  out  1  count == 0.
o_af  out  1  almost full.
o_ae  out  1  almost empty.
o_count  out  $clog2(DEPTH)+1  current occupancy.
o_overflow  out  1  1-cycle pulse: push rejected.
o_underflow  out  1  1-cycle pulse: pop rejected.
o_ram_wr_addr  out  $clog2(DEPTH)  to RAM i_wr_addr.
o_ram_wr_dv  out  1  to RAM i_wr_dv.
o_ram_wr_data  out  WIDTH  to RAM i_wr_data.
o_ram_rd_addr  out  $clog2(DEPTH)  to RAM i_rd_addr.
o_ram_rd_en  out  1  to RAM i_rd_en.
i_ram_rd_dv  in  1  from RAM o_rd_dv.
i_ram_rd_data  in  WIDTH  from RAM o_rd_data.

Behaviour:
- Clocking and reset: one clock (i_clk). i_rst is synchronous and active-high.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, o_empty=1, o_ae=1, o_full=0, o_af=0, o_rd_dv=0, o_overflow=0, o_underflow=0.
- Reset timing: all state is reset on the clock edge where i_rst=1. A pop already in flight in the RAM is discarded: o_rd_dv stays 0 on the following cycle.
- RAM contract: RAM read latency is exactly 1 cycle (i_rd_en at edge N gives o_rd_dv/o_rd_data valid after edge N+1).
- Write side, combinational: o_ram_wr_dv = push_ok; o_ram_wr_addr = wr_ptr; o_ram_wr_data = i_wr_data.
- Read side, combinational: o_ram_rd_en = pop_ok; o_ram_rd_addr = rd_ptr.
- Push accept: push_ok = i_wr_dv & ~full.
- Pop accept: pop_ok = i_rd_en & ~empty.
- Full with simultaneous push and pop: push is rejected (o_overflow pulses) and the pop is accepted. The write and read addresses therefore never collide on the same cycle.
- Empty with simultaneous push and pop: pop is rejected (o_underflow pulses) and the push is accepted. There is no write-to-read bypass.
- Pointers: wr_ptr increments on push_ok; rd_ptr increments on pop_ok. Both are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally.
- Count update: +1 on push_ok only, -1 on pop_ok only, unchanged when both or neither.
- Flags: registered, derived from the next-state count so they agree with o_count on the same cycle.
- o_rd_dv / o_rd_data: o_rd_dv = i_ram_rd_dv gated by a pending bit. The pending bit is set by pop_ok and cleared by reset. o_rd_data = i_ram_rd_data.
- Error pulses: o_overflow/o_underflow are registered and last 1 cycle per rejected request. They are not sticky.
- Throughput: one push and one pop per cycle sustained. Pop latency is 1 cycle.

Test Plan:
- Reset, then push 16'h0001..16'h0005 on 5 consecutive cycles -> RAM written at addresses 0..4; o_count=5; o_empty=0; o_ae=0 (AE_LEVEL=4).
- Pop 5 times back-to-back -> o_rd_dv high 5 consecutive cycles, each 1 cycle after its request, data 0001..0005 in order; final o_count=0, o_empty=1.
- Push 256 words -> o_full=1, o_af asserted from count 252; a 257th push gives o_overflow pulse, count stays 256, no RAM write; simultaneous push+pop while full -> pop accepted, push rejected, count=255.
- Pop while empty with simultaneous push of 16'hABCD -> o_underflow pulse, o_rd_dv stays 0, count=1; the next pop returns ABCD.
- Wrap-around: fill/drain 300 words with a continuous push+pop stream at count ~10 -> pointers wrap past 255->0, data order preserved, count constant.
- Assert i_rst the cycle after an accepted pop -> o_rd_dv=0 next cycle, count=0, o_empty=1, pointers 0.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller sequencing an external 1-cycle-latency dual-port RAM as circular storage.
// Push and pop are accepted together every cycle; a rejected request raises a one-cycle error pulse.
module ram_fifo_ctrl #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 256,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_dv,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic             o_rd_dv,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_af,
  output logic             o_ae,
  output logic [CW-1:0]    o_count,
  output logic             o_overflow,
  output logic             o_underflow,
  output logic [AW-1:0]    o_ram_wr_addr,
  output logic             o_ram_wr_dv,
  output logic [WIDTH-1:0] o_ram_wr_data,
  output logic [AW-1:0]    o_ram_rd_addr,
  output logic             o_ram_rd_en,
  input  logic             i_ram_rd_dv,
  input  logic [WIDTH-1:0] i_ram_rd_data
);

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          full_q, empty_q, af_q, ae_q;
  logic          ovf_q, unf_q, pend;
  logic          push_ok, pop_ok;

  // Gating on the registered flags means a full FIFO still drains and an empty one still fills.
  assign push_ok = i_wr_dv & ~full_q;
  assign pop_ok  = i_rd_en & ~empty_q;

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      pend    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count   <= count_nxt;
      full_q  <= (count_nxt == FULL_C);
      empty_q <= (count_nxt == '0);
      af_q    <= (count_nxt >= AF_C);
      ae_q    <= (count_nxt <= AE_C);
      ovf_q   <= i_wr_dv & full_q;
      unf_q   <= i_rd_en & empty_q;
      // Tracks the RAM read issued this cycle so reset can discard its returning data.
      pend    <= pop_ok;
    end
  end

  assign o_ram_wr_dv   = push_ok;
  assign o_ram_wr_addr = wr_ptr;
  assign o_ram_wr_data = i_wr_data;
  assign o_ram_rd_en   = pop_ok;
  assign o_ram_rd_addr = rd_ptr;

  assign o_rd_dv     = i_ram_rd_dv & pend;
  assign o_rd_data   = i_ram_rd_data;
  assign o_full      = full_q;
  assign o_empty     = empty_q;
  assign o_af        = af_q;
  assign o_ae        = ae_q;
  assign o_count     = count;
  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;

endmodule
